wb_master_interface: RTL and testbench

- Receive side of the NiC: takes flits arriving from the NoC, reassembles one packet at a time, and replays it on the node's WISHBONE bus as a pipelined master (single or incrementing burst).
- Returns one credit per consumed flit to the upstream router after the bus transaction completes.
- Read data collected from the bus is presented on a side port for the reply packetizer.

---
 rtl/wb_master_interface.sv | 315 +++++++++++++++++++++++++++++++
 tb/tb_wb_master_interface.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_master_interface.sv
// wb_master_interface
//
// Receive side of the NiC. Flits from the NoC are reassembled one packet at a
// time. Each packet is then replayed on the node's WISHBONE bus as a pipelined
// master, either as a single access or as an incrementing burst. After the
// bus transaction completes, one credit per consumed flit goes back to the
// upstream router. Read data returned by the bus appears on a side port for
// the reply packetizer.
//
// Flit format: type in [FLIT_WIDTH-1:FLIT_WIDTH-2] (01 head, 00 body,
// 10 tail, 11 head-tail).
//   Head payload, packed from bit 0: ADR, burst_len, SEL, WE.
//   Body/tail payload: data word in [BUS_DATA_WIDTH-1:0].
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_link_i         incoming flit
//   is_valid_i        in_link_i valid this cycle
//   credit_o          one credit returned per high cycle
//   CYC_O..SEL_O      WISHBONE pipelined master outputs
//   DAT_I, STALL_I,
//   ACK_I, ERR_I      WISHBONE master inputs (ERR_I terminates like ACK_I)
//   rd_data_o         captured read word
//   rd_valid_o        rd_data_o valid, one cycle per read ack
//   busy_o            high unless idle in COLLECT with no head pending
//   overflow_o        one-cycle pulse per dropped flit
//   err_o             one-cycle pulse per ERR_I received
module wb_master_interface #(
  parameter int FLIT_WIDTH          = 66,
  parameter int BUS_DATA_WIDTH      = 32,
  parameter int BUS_ADDRESS_WIDTH   = 32,
  parameter int BUS_SEL_WIDTH       = 4,
  parameter int MAX_BURST           = 8,
  parameter int N_BITS_BURST_LENGHT = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [FLIT_WIDTH-1:0]        in_link_i,
  input  logic                         is_valid_i,
  output logic                         credit_o,
  output logic                         CYC_O,
  output logic                         STB_O,
  output logic                         WE_O,
  output logic [2:0]                   CTI_O,
  output logic [BUS_ADDRESS_WIDTH-1:0] ADR_O,
  output logic [BUS_DATA_WIDTH-1:0]    DAT_O,
  output logic [BUS_SEL_WIDTH-1:0]     SEL_O,
  input  logic [BUS_DATA_WIDTH-1:0]    DAT_I,
  input  logic                         STALL_I,
  input  logic                         ACK_I,
  input  logic                         ERR_I,
  output logic [BUS_DATA_WIDTH-1:0]    rd_data_o,
  output logic                         rd_valid_o,
  output logic                         busy_o,
  output logic                         overflow_o,
  output logic                         err_o
);

  localparam int NBL     = N_BITS_BURST_LENGHT;
  localparam int IDXW    = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int LEN_LSB = BUS_ADDRESS_WIDTH;
  localparam int SEL_LSB = LEN_LSB + NBL;
  localparam int WE_BIT  = SEL_LSB + BUS_SEL_WIDTH;

  localparam logic [NBL-1:0]               ONE_C    = NBL'(1);
  localparam logic [NBL-1:0]               MAX_C    = NBL'(MAX_BURST);
  localparam logic [BUS_ADDRESS_WIDTH-1:0] ADR_STEP = BUS_ADDRESS_WIDTH'(BUS_DATA_WIDTH / 8);

  typedef enum logic [1:0] {
    S_COLLECT,
    S_BUS,
    S_CREDIT
  } state_e;

  typedef enum logic [1:0] {
    F_BODY      = 2'b00,
    F_HEAD      = 2'b01,
    F_TAIL      = 2'b10,
    F_HEAD_TAIL = 2'b11
  } flit_e;

  // Flit field decode
  flit_e                        ftype;
  logic [BUS_ADDRESS_WIDTH-1:0] h_adr;
  logic [NBL-1:0]               h_len;
  logic [BUS_SEL_WIDTH-1:0]     h_sel;
  logic                         h_we;
  logic [BUS_DATA_WIDTH-1:0]    data_word;
  logic                         unused_flit_bits;

  assign ftype            = flit_e'(in_link_i[FLIT_WIDTH-1 -: 2]);
  assign h_adr            = in_link_i[BUS_ADDRESS_WIDTH-1:0];
  assign h_len            = in_link_i[LEN_LSB +: NBL];
  assign h_sel            = in_link_i[SEL_LSB +: BUS_SEL_WIDTH];
  assign h_we             = in_link_i[WE_BIT];
  assign data_word        = in_link_i[BUS_DATA_WIDTH-1:0];
  assign unused_flit_bits = ^in_link_i[FLIT_WIDTH-3:WE_BIT+1];

  // State
  state_e                       state_q, state_d;
  logic                         head_pend_q, head_pend_d;
  logic [BUS_ADDRESS_WIDTH-1:0] adr_q, adr_d;
  logic [NBL-1:0]               len_q, len_d;
  logic [BUS_SEL_WIDTH-1:0]     sel_q, sel_d;
  logic                         we_q, we_d;
  logic [NBL-1:0]               flit_cnt_q, flit_cnt_d;
  logic [NBL-1:0]               n_words_q, n_words_d;
  logic [NBL-1:0]               stb_cnt_q, stb_cnt_d;
  logic [NBL-1:0]               ack_cnt_q, ack_cnt_d;
  logic                         cyc_q, cyc_d;
  logic                         stb_q, stb_d;
  logic                         overflow_q, overflow_d;
  logic                         err_q, err_d;
  logic                         rd_valid_q, rd_valid_d;
  logic [BUS_DATA_WIDTH-1:0]    rd_data_q, rd_data_d;

  // Packet data buffer; contents only matter while a strobe is being issued
  logic [BUS_DATA_WIDTH-1:0]    wbuf_q [MAX_BURST];
  logic                         buf_we;
  logic [IDXW-1:0]              buf_idx;

  // Combinational helpers
  logic [NBL-1:0]               data_idx;
  logic [NBL-1:0]               n_words_nxt;
  logic                         finish;
  logic                         accept;
  logic                         term;

  assign data_idx = flit_cnt_q - ONE_C;
  assign accept   = stb_q && !STALL_I;
  assign term     = cyc_q && (ACK_I || ERR_I);

  function automatic logic [NBL-1:0] clamp_words(input logic [NBL-1:0] v);
    return (v > MAX_C) ? MAX_C : v;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_COLLECT;
      head_pend_q <= 1'b0;
      adr_q       <= '0;
      len_q       <= '0;
      sel_q       <= '0;
      we_q        <= 1'b0;
      flit_cnt_q  <= '0;
      n_words_q   <= '0;
      stb_cnt_q   <= '0;
      ack_cnt_q   <= '0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      overflow_q  <= 1'b0;
      err_q       <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      head_pend_q <= head_pend_d;
      adr_q       <= adr_d;
      len_q       <= len_d;
      sel_q       <= sel_d;
      we_q        <= we_d;
      flit_cnt_q  <= flit_cnt_d;
      n_words_q   <= n_words_d;
      stb_cnt_q   <= stb_cnt_d;
      ack_cnt_q   <= ack_cnt_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      overflow_q  <= overflow_d;
      err_q       <= err_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (buf_we) begin
      wbuf_q[buf_idx] <= data_word;
    end
  end

  always_comb begin
    state_d     = state_q;
    head_pend_d = head_pend_q;
    adr_d       = adr_q;
    len_d       = len_q;
    sel_d       = sel_q;
    we_d        = we_q;
    flit_cnt_d  = flit_cnt_q;
    n_words_d   = n_words_q;
    stb_cnt_d   = stb_cnt_q;
    ack_cnt_d   = ack_cnt_q;
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    overflow_d  = 1'b0;
    err_d       = 1'b0;
    rd_valid_d  = 1'b0;
    rd_data_d   = rd_data_q;
    buf_we      = 1'b0;
    buf_idx     = '0;
    n_words_nxt = '0;
    finish      = 1'b0;

    unique case (state_q)
      S_COLLECT: begin
        if (is_valid_i) begin
          if (ftype == F_HEAD || ftype == F_HEAD_TAIL) begin
            adr_d       = h_adr;
            len_d       = h_len;
            sel_d       = h_sel;
            we_d        = h_we;
            flit_cnt_d  = ONE_C;
            head_pend_d = (ftype == F_HEAD);
            if (ftype == F_HEAD_TAIL) begin
              // A head-tail carries no data, so a write has nothing to issue
              n_words_nxt = h_we ? '0 : clamp_words(h_len);
              finish      = 1'b1;
            end
          end else if (!head_pend_q) begin
            overflow_d = 1'b1;
          end else begin
            flit_cnt_d = flit_cnt_q + ONE_C;
            if (data_idx < MAX_C) begin
              buf_we  = 1'b1;
              buf_idx = data_idx[IDXW-1:0];
            end else begin
              overflow_d = 1'b1;
            end
            if (ftype == F_TAIL) begin
              head_pend_d = 1'b0;
              // flit_cnt_q equals the data-flit count including this tail
              n_words_nxt = we_q ? clamp_words(flit_cnt_q) : clamp_words(len_q);
              finish      = 1'b1;
            end
          end
        end
        if (finish) begin
          n_words_d = n_words_nxt;
          stb_cnt_d = '0;
          ack_cnt_d = '0;
          if (n_words_nxt == '0) begin
            state_d = S_CREDIT;
          end else begin
            state_d = S_BUS;
            cyc_d   = 1'b1;
            stb_d   = 1'b1;
          end
        end
      end

      S_BUS: begin
        if (is_valid_i) begin
          overflow_d = 1'b1;
        end
        if (accept) begin
          stb_cnt_d = stb_cnt_q + ONE_C;
          adr_d     = adr_q + ADR_STEP;
          if (stb_cnt_q == n_words_q - ONE_C) begin
            stb_d = 1'b0;
          end
        end
        if (term) begin
          ack_cnt_d  = ack_cnt_q + ONE_C;
          err_d      = ERR_I;
          rd_valid_d = ACK_I && !ERR_I && !we_q;
          if (ACK_I && !ERR_I && !we_q) begin
            rd_data_d = DAT_I;
          end
          if (ack_cnt_q == n_words_q - ONE_C) begin
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
            state_d = S_CREDIT;
          end
        end
      end

      S_CREDIT: begin
        if (is_valid_i) begin
          overflow_d = 1'b1;
        end
        // flit_cnt doubles as the remaining-credit counter
        flit_cnt_d = flit_cnt_q - ONE_C;
        if (flit_cnt_q <= ONE_C) begin
          flit_cnt_d = '0;
          state_d    = S_COLLECT;
        end
      end

      default: begin
        state_d = S_COLLECT;
      end
    endcase
  end

  // Outputs
  assign credit_o   = (state_q == S_CREDIT);
  assign busy_o     = (state_q != S_COLLECT) || head_pend_q;
  assign CYC_O      = cyc_q;
  assign STB_O      = stb_q;
  assign WE_O       = cyc_q && we_q;
  assign ADR_O      = cyc_q ? adr_q : '0;
  assign SEL_O      = cyc_q ? sel_q : '0;
  assign DAT_O      = (stb_q && we_q) ? wbuf_q[stb_cnt_q[IDXW-1:0]] : '0;
  assign overflow_o = overflow_q;
  assign err_o      = err_q;
  assign rd_valid_o = rd_valid_q;
  assign rd_data_o  = rd_data_q;

  always_comb begin
    CTI_O = 3'b000;
    if (stb_q && (n_words_q != ONE_C)) begin
      CTI_O = (stb_cnt_q == n_words_q - ONE_C) ? 3'b111 : 3'b010;
    end
  end

endmodule

// File: tb/tb_wb_master_interface.sv
module tb_wb_master_interface;

  logic        clk = 1'b0;
  logic        rst;
  logic [65:0] in_link_i;
  logic        is_valid_i;
  logic        credit_o;
  logic        CYC_O, STB_O, WE_O;
  logic [2:0]  CTI_O;
  logic [31:0] ADR_O, DAT_O, DAT_I, rd_data_o;
  logic [3:0]  SEL_O;
  logic        STALL_I, ACK_I, ERR_I;
  logic        rd_valid_o, busy_o, overflow_o, err_o;

  always #5 clk = ~clk;

  wb_master_interface #(
    .FLIT_WIDTH(66), .BUS_DATA_WIDTH(32), .BUS_ADDRESS_WIDTH(32),
    .BUS_SEL_WIDTH(4), .MAX_BURST(8), .N_BITS_BURST_LENGHT(4)
  ) dut (
    .clk(clk), .rst(rst), .in_link_i(in_link_i), .is_valid_i(is_valid_i),
    .credit_o(credit_o), .CYC_O(CYC_O), .STB_O(STB_O), .WE_O(WE_O),
    .CTI_O(CTI_O), .ADR_O(ADR_O), .DAT_O(DAT_O), .SEL_O(SEL_O),
    .DAT_I(DAT_I), .STALL_I(STALL_I), .ACK_I(ACK_I), .ERR_I(ERR_I),
    .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o), .busy_o(busy_o),
    .overflow_o(overflow_o), .err_o(err_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Pulse counters sampled on the inactive edge
  int c_credit = 0, c_ovf = 0, c_err = 0, c_rdv = 0;
  always @(negedge clk) begin
    if (credit_o)   c_credit++;
    if (overflow_o) c_ovf++;
    if (err_o)      c_err++;
    if (rd_valid_o) c_rdv++;
  end

  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic        we;
    logic [2:0]  cti;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        credit;
    logic        busy;
    logic        ovf;
    logic        rdv;
    logic [31:0] rdd;
    logic        err;
  } outs_t;

  typedef struct {
    logic        vld;
    logic [65:0] flit;
    logic        ack;
    logic [31:0] dat_i;
    outs_t       exp;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs[NVEC];

  logic [31:0] acc_adr[$];
  logic [31:0] acc_dat[$];
  logic [2:0]  acc_cti[$];
  int          hold_bad;
  int          n_term;

  function automatic logic [65:0] hd(input logic [1:0] t, input logic [31:0] adr,
                                     input logic [3:0] len, input logic [3:0] sel,
                                     input logic we);
    return {t, 23'b0, we, sel, len, adr};
  endfunction

  function automatic logic [65:0] dw(input logic [1:0] t, input logic [31:0] w);
    return {t, 32'b0, w};
  endfunction

  function automatic outs_t idle(input logic credit, input logic busy, input logic ovf,
                                 input logic rdv, input logic [31:0] rdd);
    return {1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 4'h0, credit, busy, ovf, rdv, rdd, 1'b0};
  endfunction

  function automatic outs_t bus(input logic cyc, input logic stb, input logic we,
                                input logic [2:0] cti, input logic [31:0] adr,
                                input logic [31:0] dat, input logic [3:0] sel,
                                input logic rdv, input logic [31:0] rdd);
    return {cyc, stb, we, cti, adr, dat, sel, 1'b0, 1'b1, 1'b0, rdv, rdd, 1'b0};
  endfunction

  function automatic vec_t v(input logic vld, input logic [65:0] flit, input logic ack,
                             input logic [31:0] dat_i, input outs_t exp);
    vec_t r;
    r.vld = vld; r.flit = flit; r.ack = ack; r.dat_i = dat_i; r.exp = exp;
    return r;
  endfunction

  function automatic outs_t sample();
    return {CYC_O, STB_O, WE_O, CTI_O, ADR_O, DAT_O, SEL_O, credit_o, busy_o,
            overflow_o, rd_valid_o, rd_data_o, err_o};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [65:0] f);
    is_valid_i = 1'b1;
    in_link_i  = f;
    step();
    is_valid_i = 1'b0;
    in_link_i  = '0;
  endtask

  // Behavioural pipelined slave: acks each accepted strobe one cycle later
  task automatic run_bus(input int stall_at, input int stall_len, input int err_at,
                         input int inject_at);
    int stb_idx = 0, stall_left = stall_len, pend = 0, cyc_n = 0;
    logic stall, acc, term;
    logic [31:0] h_adr, h_dat;
    logic [2:0]  h_cti;
    acc_adr.delete(); acc_dat.delete(); acc_cti.delete();
    hold_bad = 0;
    n_term   = 0;
    while (CYC_O && cyc_n < 200) begin
      stall      = STB_O && (stb_idx == stall_at) && (stall_left > 0);
      acc        = STB_O && !stall;
      term       = (pend > 0);
      STALL_I    = stall;
      ACK_I      = term && (n_term != err_at);
      ERR_I      = term && (n_term == err_at);
      DAT_I      = 32'h5000 + n_term;
      is_valid_i = (cyc_n == inject_at);
      in_link_i  = dw(2'b00, 32'hEEEE);
      if (acc) begin
        acc_adr.push_back(ADR_O);
        acc_dat.push_back(DAT_O);
        acc_cti.push_back(CTI_O);
        stb_idx++;
      end
      h_adr = ADR_O; h_dat = DAT_O; h_cti = CTI_O;
      if (stall) stall_left--;
      step();
      if (stall && (!STB_O || ADR_O !== h_adr || DAT_O !== h_dat || CTI_O !== h_cti))
        hold_bad++;
      if (term) n_term++;
      pend += (acc ? 1 : 0) - (term ? 1 : 0);
      cyc_n++;
    end
    STALL_I = 1'b0; ACK_I = 1'b0; ERR_I = 1'b0; is_valid_i = 1'b0; in_link_i = '0;
    chk("bus_done_in_time", 128'(cyc_n < 200), 128'(1));
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy_o && n < 100) begin
      step();
      n++;
    end
    chk("idle_in_time", 128'(busy_o), 128'(0));
  endtask

  task automatic check_burst(input string nm, input logic [31:0] adr0,
                             input logic [31:0] dat0, input int n);
    chk({nm, "_count"}, 128'(acc_adr.size()), 128'(n));
    for (int i = 0; i < n && i < acc_adr.size(); i++) begin
      chk($sformatf("%s_adr%0d", nm, i), 128'(acc_adr[i]), 128'(adr0 + 32'(4 * i)));
      chk($sformatf("%s_dat%0d", nm, i), 128'(acc_dat[i]), 128'(dat0 + 32'(i)));
      chk($sformatf("%s_cti%0d", nm, i), 128'(acc_cti[i]),
          128'((n == 1) ? 3'b000 : (i == n - 1) ? 3'b111 : 3'b010));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int b_cr, b_ov, b_er, b_rv;

    // Write single, zero-length write, read burst, stray body, stray ack
    vecs[0]  = v(1, hd(2'b01, 32'h100, 4'd1, 4'hF, 1'b1), 0, 0, idle(0, 1, 0, 0, 0));
    vecs[1]  = v(1, dw(2'b10, 32'hDEADBEEF), 0, 0,
                 bus(1, 1, 1, 3'b000, 32'h100, 32'hDEADBEEF, 4'hF, 0, 0));
    vecs[2]  = v(0, '0, 0, 0, bus(1, 0, 1, 3'b000, 32'h104, 32'h0, 4'hF, 0, 0));
    vecs[3]  = v(0, '0, 1, 0, idle(1, 1, 0, 0, 0));
    vecs[4]  = v(0, '0, 0, 0, idle(1, 1, 0, 0, 0));
    vecs[5]  = v(0, '0, 0, 0, idle(0, 0, 0, 0, 0));
    vecs[6]  = v(1, hd(2'b11, 32'h300, 4'd5, 4'h3, 1'b1), 0, 0, idle(1, 1, 0, 0, 0));
    vecs[7]  = v(0, '0, 0, 0, idle(0, 0, 0, 0, 0));
    vecs[8]  = v(1, hd(2'b11, 32'h40, 4'd4, 4'hF, 1'b0), 0, 0,
                 bus(1, 1, 0, 3'b010, 32'h40, 32'h0, 4'hF, 0, 0));
    vecs[9]  = v(0, '0, 0, 0, bus(1, 1, 0, 3'b010, 32'h44, 32'h0, 4'hF, 0, 0));
    vecs[10] = v(0, '0, 1, 32'd1, bus(1, 1, 0, 3'b010, 32'h48, 32'h0, 4'hF, 1, 32'd1));
    vecs[11] = v(0, '0, 1, 32'd2, bus(1, 1, 0, 3'b111, 32'h4C, 32'h0, 4'hF, 1, 32'd2));
    vecs[12] = v(0, '0, 1, 32'd3, bus(1, 0, 0, 3'b000, 32'h50, 32'h0, 4'hF, 1, 32'd3));
    vecs[13] = v(0, '0, 1, 32'd4, idle(1, 1, 0, 1, 32'd4));
    vecs[14] = v(0, '0, 0, 0, idle(0, 0, 0, 0, 32'd4));
    vecs[15] = v(1, dw(2'b00, 32'h1234), 0, 0, idle(0, 0, 1, 0, 32'd4));
    vecs[16] = v(0, '0, 1, 32'h99, idle(0, 0, 0, 0, 32'd4));

    rst = 1'b1; is_valid_i = 1'b0; in_link_i = '0;
    STALL_I = 1'b0; ACK_I = 1'b0; ERR_I = 1'b0; DAT_I = '0;
    step();
    step();
    chk("reset_outputs", 128'(sample()), 128'(0));
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      is_valid_i = vecs[i].vld;
      in_link_i  = vecs[i].flit;
      ACK_I      = vecs[i].ack;
      DAT_I      = vecs[i].dat_i;
      step();
      chk($sformatf("vec%0d", i), 128'(sample()), 128'(vecs[i].exp));
    end
    is_valid_i = 1'b0; in_link_i = '0; ACK_I = 1'b0; DAT_I = '0;
    step();

    // Write burst of 4 with a 3-cycle stall on the second strobe
    b_cr = c_credit; b_ov = c_ovf;
    send(hd(2'b01, 32'h200, 4'd4, 4'hF, 1'b1));
    for (int i = 0; i < 3; i++) send(dw(2'b00, 32'hA0 + 32'(i)));
    send(dw(2'b10, 32'hA3));
    chk("burst_cyc_up", 128'(CYC_O), 128'(1));
    run_bus(1, 3, -1, -1);
    wait_idle();
    check_burst("stall", 32'h200, 32'hA0, 4);
    chk("stall_hold", 128'(hold_bad), 128'(0));
    chk("stall_credits", 128'(c_credit - b_cr), 128'(5));
    chk("stall_ovf", 128'(c_ovf - b_ov), 128'(0));

    // Overflow: head + 9 body + tail, plus one flit injected during BUS
    b_cr = c_credit; b_ov = c_ovf;
    send(hd(2'b01, 32'h500, 4'd0, 4'hF, 1'b1));
    for (int i = 0; i < 9; i++) send(dw(2'b00, 32'hB0 + 32'(i)));
    send(dw(2'b10, 32'hB9));
    run_bus(-1, 0, -1, 2);
    wait_idle();
    check_burst("ovf", 32'h500, 32'hB0, 8);
    chk("ovf_pulses", 128'(c_ovf - b_ov), 128'(3));
    chk("ovf_credits", 128'(c_credit - b_cr), 128'(11));

    // ERR_I on the second termination of a 3-word write
    b_cr = c_credit; b_er = c_err; b_rv = c_rdv;
    send(hd(2'b01, 32'h600, 4'd3, 4'hF, 1'b1));
    send(dw(2'b00, 32'hC0));
    send(dw(2'b00, 32'hC1));
    send(dw(2'b10, 32'hC2));
    run_bus(-1, 0, 1, -1);
    wait_idle();
    check_burst("err", 32'h600, 32'hC0, 3);
    chk("err_terms", 128'(n_term), 128'(3));
    chk("err_pulses", 128'(c_err - b_er), 128'(1));
    chk("err_no_rdv", 128'(c_rdv - b_rv), 128'(0));
    chk("err_credits", 128'(c_credit - b_cr), 128'(4));

    // Reset in the middle of a burst, then a normal packet
    send(hd(2'b01, 32'h700, 4'd2, 4'hF, 1'b1));
    send(dw(2'b00, 32'hD0));
    send(dw(2'b10, 32'hD1));
    chk("rst_cyc_up", 128'(CYC_O), 128'(1));
    step();
    rst = 1'b1;
    step();
    chk("rst_mid_burst", 128'(sample()), 128'(0));
    rst = 1'b0;
    b_cr = c_credit;
    for (int i = 0; i < 4; i++) step();
    chk("rst_no_credit", 128'(c_credit - b_cr), 128'(0));
    chk("rst_not_busy", 128'(busy_o), 128'(0));

    b_cr = c_credit;
    send(hd(2'b01, 32'h800, 4'd1, 4'h5, 1'b1));
    send(dw(2'b10, 32'h11223344));
    chk("after_rst_sel", 128'(SEL_O), 128'(4'h5));
    run_bus(-1, 0, -1, -1);
    wait_idle();
    check_burst("after_rst", 32'h800, 32'h11223344, 1);
    chk("after_rst_credits", 128'(c_credit - b_cr), 128'(2));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
